program_counter_unit: RTL

//  Parametrised fetch-stage program counter. It replaces the bare PC register with a unit

---
 rtl/program_counter_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/program_counter_unit.sv
// Fetch-stage PC with reset/exception vectors, branch redirect, stall and req/ack fetch.
// Define PC_TRACE_EN to add a circular trace of PcOut values at each applied redirect.
module program_counter_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(4),
  parameter int          STEP         = 4,
  parameter int          TRACE_DEPTH  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branchTaken,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic             exception,
  output logic             fetchReq,
  input  logic             fetchAck,
  output logic [WIDTH-1:0] PcOut,
  output logic [WIDTH-1:0] PcPlus4,
  output logic [WIDTH-1:0] PcPlus8
`ifdef PC_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] traceIdx,
  output logic [WIDTH-1:0]               traceData,
  output logic [$clog2(TRACE_DEPTH):0]   traceCount
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    STALL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pv_q, pv_d;
  logic             pe_q, pe_d;
  logic [WIDTH-1:0] pt_q, pt_d;
  logic             trace_we;

  logic             redir;
  logic [WIDTH-1:0] redir_tgt;
  logic [WIDTH-1:0] br_tgt;

  assign br_tgt    = {branchTarget[WIDTH-1:2], 2'b00};
  assign redir     = exception | branchTaken;
  assign redir_tgt = exception ? EXC_VECTOR : br_tgt;

  assign fetchReq = (state_q == FETCH);
  assign PcOut    = pc_q;
  assign PcPlus4  = pc_q + WIDTH'(4);
  assign PcPlus8  = pc_q + WIDTH'(8);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pv_d     = pv_q;
    pe_d     = pe_q;
    pt_d     = pt_q;
    trace_we = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redir) begin
          pc_d     = redir_tgt;
          trace_we = 1'b1;
          pv_d     = 1'b0;
          pe_d     = 1'b0;
        end
      end
      FETCH: begin
        if (stall) state_d = STALL;
        if (fetchAck) begin
          pv_d = 1'b0;
          pe_d = 1'b0;
          if (redir) begin
            pc_d     = redir_tgt;
            trace_we = 1'b1;
          end else if (pv_q) begin
            pc_d     = pt_q;
            trace_we = 1'b1;
          end else begin
            pc_d = pc_q + WIDTH'(STEP);
          end
        end else if (exception) begin
          // Address must hold; park the redirect until the transfer completes.
          pv_d = 1'b1;
          pe_d = 1'b1;
          pt_d = EXC_VECTOR;
        end else if (branchTaken && !pe_q) begin
          pv_d = 1'b1;
          pt_d = br_tgt;
        end
      end
      STALL: begin
        if (!stall) state_d = FETCH;
        if (redir) begin
          pc_d     = redir_tgt;
          trace_we = 1'b1;
          pv_d     = 1'b0;
          pe_d     = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pv_q    <= 1'b0;
      pe_q    <= 1'b0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      pt_q    <= pt_d;
    end
  end

`ifdef PC_TRACE_EN
  localparam int IW = $clog2(TRACE_DEPTH);

  logic [WIDTH-1:0] buf_q [TRACE_DEPTH];
  logic [IW-1:0]    wr_q;
  logic [IW:0]      cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (trace_we) begin
      wr_q <= wr_q + IW'(1);
      if (cnt_q != (IW+1)'(TRACE_DEPTH)) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (trace_we) buf_q[wr_q] <= pc_q;
  end

  assign traceData  = buf_q[wr_q - IW'(1) - traceIdx];
  assign traceCount = cnt_q;
`else
  logic unused_trace;
  assign unused_trace = trace_we;
`endif

endmodule
